// File: rtl/alu_op_sequencer_pkg.sv
// Shared types and flag layout for the ALU op sequencer.
// The flag constants are only used when ALU_SEQ_FLAGS_EN is defined.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_PASS = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int FLAGS_W    = 3;
  localparam int FLAG_CARRY = 0;
  localparam int FLAG_OVF   = 1;
  localparam int FLAG_ZERO  = 2;

  function automatic logic [FLAGS_W-1:0] pack_flags(input logic zero, input logic ovf,
                                                    input logic carry);
    logic [FLAGS_W-1:0] f;
    f             = '0;
    f[FLAG_ZERO]  = zero;
    f[FLAG_OVF]   = ovf;
    f[FLAG_CARRY] = carry;
    return f;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command/result handshake bundle between the bus side and the sequencer.
// res_flags exists only when ALU_SEQ_FLAGS_EN is defined.
interface alu_op_sequencer_if #(parameter int WIDTH = 8);
  import alu_seq_pkg::*;

  logic             req_valid;
  logic             req_ready;
  op_t              req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [WIDTH-1:0] req_c;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
`ifdef ALU_SEQ_FLAGS_EN
  logic [FLAGS_W-1:0] res_flags;

  modport master (output req_valid, req_op, req_a, req_b, req_c, res_ready,
                  input  req_ready, res_valid, res_data, res_flags);
  modport slave  (input  req_valid, req_op, req_a, req_b, req_c, res_ready,
                  output req_ready, res_valid, res_data, res_flags);
`else
  modport master (output req_valid, req_op, req_a, req_b, req_c, res_ready,
                  input  req_ready, res_valid, res_data);
  modport slave  (input  req_valid, req_op, req_a, req_b, req_c, res_ready,
                  output req_ready, res_valid, res_data);
`endif

endinterface

// File: rtl/alu_op_sequencer_shift_add_mul.sv
// Iterative shift-add multiplier: one partial product per cycle after start.
// done is high in the cycle whose edge completes the last step; product is then final.
module shift_add_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int IW = $clog2(WIDTH) + 1;
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [IW-1:0]      iter_r;
  logic               run_r;
  logic [2*WIDTH-1:0] acc_next_s;

  // Next accumulator value; exposed as product so the last step is captured without a bubble.
  always_comb begin
    if (mplier_r[0]) begin
      acc_next_s = acc_r + mcand_r;
    end else begin
      acc_next_s = acc_r;
    end
  end

  assign done    = run_r && (iter_r == LAST);
  assign product = acc_next_s;

  // Operand load on start, then one shift-add step per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_r    <= '0;
      mcand_r  <= '0;
      mplier_r <= '0;
      iter_r   <= '0;
      run_r    <= 1'b0;
    end else if (clr) begin
      run_r    <= 1'b0;
    end else if (start) begin
      acc_r    <= '0;
      mcand_r  <= {{WIDTH{1'b0}}, a};
      mplier_r <= b;
      iter_r   <= '0;
      run_r    <= 1'b1;
    end else if (run_r) begin
      acc_r    <= acc_next_s;
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      iter_r   <= iter_r + {{(IW-1){1'b0}}, 1'b1};
      run_r    <= !done;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Command front end for the ALU: single-cycle ADD/SUB/PASS, iterative MUL, held result.
// Optional result flags {zero, ovf, carry} are built when ALU_SEQ_FLAGS_EN is defined.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  alu_op_sequencer_if.slave  bus,
  output logic               busy,
  output logic [CNT_W-1:0]   done_count
);

  state_t             state_r;
  logic               mul_start_s;
  logic               mul_done_s;
  logic [2*WIDTH-1:0] mul_product_s;
  logic [WIDTH:0]     add_s;
  logic [WIDTH-1:0]   alu_result_s;

  assign mul_start_s = (state_r == IDLE) && bus.req_valid && !clr && (bus.req_op == OP_MUL);

  shift_add_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr),
    .start   (mul_start_s),
    .a       (bus.req_a),
    .b       (bus.req_b),
    .done    (mul_done_s),
    .product (mul_product_s)
  );

  // Single-cycle result for ADD/SUB/PASS, taken straight from the request operands.
  always_comb begin
    add_s = {1'b0, bus.req_a} + {1'b0, bus.req_b};
    case (bus.req_op)
      OP_ADD:  alu_result_s = add_s[WIDTH-1:0];
      OP_SUB:  alu_result_s = bus.req_a - bus.req_b;
      OP_PASS: alu_result_s = bus.req_c;
      default: alu_result_s = '0;
    endcase
  end

`ifdef ALU_SEQ_FLAGS_EN
  logic [FLAGS_W-1:0] alu_flags_s;
  logic [FLAGS_W-1:0] mul_flags_s;
  logic               carry_s;

  // Carry is ADD carry-out or SUB borrow; ovf only reports a lost MUL upper half.
  always_comb begin
    case (bus.req_op)
      OP_ADD:  carry_s = add_s[WIDTH];
      OP_SUB:  carry_s = (bus.req_a < bus.req_b);
      default: carry_s = 1'b0;
    endcase
    alu_flags_s = pack_flags(alu_result_s == '0, 1'b0, carry_s);
    mul_flags_s = pack_flags(mul_product_s[WIDTH-1:0] == '0,
                             |mul_product_s[2*WIDTH-1:WIDTH], 1'b0);
  end
`else
  logic unused_flag_bits_s;
  assign unused_flag_bits_s = ^{add_s[WIDTH], mul_product_s[2*WIDTH-1:WIDTH]};
`endif

  // Control FSM with registered handshake outputs; clr aborts without counting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      bus.req_ready <= 1'b1;
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      busy          <= 1'b0;
      done_count    <= '0;
`ifdef ALU_SEQ_FLAGS_EN
      bus.res_flags <= '0;
`endif
    end else if (clr) begin
      state_r       <= IDLE;
      bus.req_ready <= 1'b1;
      bus.res_valid <= 1'b0;
      busy          <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.req_valid) begin
            busy          <= 1'b1;
            bus.req_ready <= 1'b0;
            if (bus.req_op == OP_MUL) begin
              state_r       <= MUL;
            end else begin
              state_r       <= DONE;
              bus.res_valid <= 1'b1;
              bus.res_data  <= alu_result_s;
`ifdef ALU_SEQ_FLAGS_EN
              bus.res_flags <= alu_flags_s;
`endif
            end
          end
        end
        MUL: begin
          if (mul_done_s) begin
            state_r       <= DONE;
            bus.res_valid <= 1'b1;
            bus.res_data  <= mul_product_s[WIDTH-1:0];
`ifdef ALU_SEQ_FLAGS_EN
            bus.res_flags <= mul_flags_s;
`endif
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            state_r       <= IDLE;
            bus.res_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            busy          <= 1'b0;
            done_count    <= done_count + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_r       <= IDLE;
          bus.res_valid <= 1'b0;
          bus.req_ready <= 1'b1;
          busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer; flag checks compile in with ALU_SEQ_FLAGS_EN.
// CNT_W is reduced to 4 so the completed-op counter wrap is reachable.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             clr;
  logic             busy;
  logic [CNT_W-1:0] done_count;

  alu_op_sequencer_if #(.WIDTH(WIDTH)) bus_if ();

  alu_op_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .clr        (clr),
    .bus        (bus_if),
    .busy       (busy),
    .done_count (done_count)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          exp_count = 0;
  logic [10:0] sb_q[$];
  logic [10:0] mon_exp;
  logic [CNT_W-1:0] cnt_before;
  logic        seen_valid;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference result: {zero, ovf, carry, data}
  function automatic logic [10:0] model(input op_t op, input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c);
    logic [15:0] full;
    logic [7:0]  d;
    logic        ovf;
    logic        cy;
    full = 16'd0;
    ovf  = 1'b0;
    cy   = 1'b0;
    case (op)
      OP_ADD:  begin full = 16'(a) + 16'(b); d = full[7:0]; cy = full[8]; end
      OP_SUB:  begin d = a - b; cy = (a < b); end
      OP_MUL:  begin full = 16'(a) * 16'(b); d = full[7:0]; ovf = (full[15:8] != 8'd0); end
      default: d = c;
    endcase
    return {(d == 8'd0), ovf, cy, d};
  endfunction

  // Result monitor: pop and compare on every result handshake.
  always @(negedge clk) begin
    if (!reset && bus_if.res_valid && bus_if.res_ready) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
      end else begin
        mon_exp = sb_q.pop_front();
        check_eq("res_data", 32'(bus_if.res_data), 32'(mon_exp[7:0]));
`ifdef ALU_SEQ_FLAGS_EN
        check_eq("res_flags", 32'(bus_if.res_flags), 32'(mon_exp[10:8]));
`endif
        exp_count++;
      end
    end
  end

  task automatic issue(input op_t op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input bit push);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus_if.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) check_eq("req_ready_wait", 32'(bus_if.req_ready), 32'd1);
    bus_if.req_valid = 1'b1;
    bus_if.req_op    = op;
    bus_if.req_a     = a;
    bus_if.req_b     = b;
    bus_if.req_c     = c;
    if (push) sb_q.push_back(model(op, a, b, c));
    @(posedge clk);
    #1;
    bus_if.req_valid = 1'b0;
  endtask

  initial begin
    int n;
    reset            = 1'b1;
    clr              = 1'b0;
    bus_if.req_valid = 1'b0;
    bus_if.req_op    = OP_ADD;
    bus_if.req_a     = 8'd0;
    bus_if.req_b     = 8'd0;
    bus_if.req_c     = 8'd0;
    bus_if.res_ready = 1'b1;
    #12;
    check_eq("rst_req_ready", 32'(bus_if.req_ready), 32'd1);
    check_eq("rst_res_valid", 32'(bus_if.res_valid), 32'd0);
    check_eq("rst_res_data", 32'(bus_if.res_data), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_count", 32'(done_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // ADD: result in the cycle after accept, count after handshake
    issue(OP_ADD, 8'd5, 8'd3, 8'd0, 1'b1);
    check_eq("add_latency", 32'(bus_if.res_valid), 32'd1);
    check_eq("add_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check_eq("add_count", 32'(done_count), 32'd1);
    check_eq("add_released", 32'(bus_if.res_valid), 32'd0);

    issue(OP_SUB, 8'd3, 8'd5, 8'd0, 1'b1);
    @(posedge clk); #1;

    // MUL: valid appears exactly WIDTH edges after accept
    issue(OP_MUL, 8'd15, 8'd17, 8'd0, 1'b1);
    repeat (WIDTH - 1) @(posedge clk);
    #1;
    check_eq("mul_lat_early", 32'(bus_if.res_valid), 32'd0);
    @(posedge clk); #1;
    check_eq("mul_latency", 32'(bus_if.res_valid), 32'd1);
    @(posedge clk); #1;

    issue(OP_MUL, 8'd16, 8'd16, 8'd0, 1'b1);
    repeat (WIDTH + 1) @(posedge clk);
    #1;

    // Backpressure: result held, new request ignored
    bus_if.res_ready = 1'b0;
    issue(OP_ADD, 8'd7, 8'd9, 8'd0, 1'b1);
    repeat (5) begin
      @(negedge clk);
      check_eq("bp_valid", 32'(bus_if.res_valid), 32'd1);
      check_eq("bp_data", 32'(bus_if.res_data), 32'd16);
      check_eq("bp_req_ready", 32'(bus_if.req_ready), 32'd0);
      bus_if.req_valid = 1'b1;
      bus_if.req_op    = OP_SUB;
      bus_if.req_a     = 8'd1;
      bus_if.req_b     = 8'd1;
    end
    @(posedge clk); #1;
    bus_if.req_valid = 1'b0;
    check_eq("bp_busy", 32'(busy), 32'd1);
    bus_if.res_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("bp_released", 32'(bus_if.res_valid), 32'd0);
    check_eq("bp_idle", 32'(bus_if.req_ready), 32'd1);
    check_eq("bp_count", 32'(done_count), 32'(exp_count & 15));

    // clr in the 4th MUL cycle
    cnt_before = done_count;
    issue(OP_MUL, 8'd9, 8'd9, 8'd0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    check_eq("clr_busy", 32'(busy), 32'd0);
    check_eq("clr_req_ready", 32'(bus_if.req_ready), 32'd1);
    seen_valid = 1'b0;
    repeat (WIDTH) begin
      @(negedge clk);
      seen_valid = seen_valid | bus_if.res_valid;
    end
    check_eq("clr_no_result", 32'(seen_valid), 32'd0);
    check_eq("clr_count", 32'(done_count), 32'(cnt_before));
    issue(OP_ADD, 8'd1, 8'd1, 8'd0, 1'b1);
    @(posedge clk); #1;

    // clr beats req_valid in IDLE
    @(negedge clk);
    clr              = 1'b1;
    bus_if.req_valid = 1'b1;
    bus_if.req_op    = OP_ADD;
    bus_if.req_a     = 8'd2;
    bus_if.req_b     = 8'd2;
    @(posedge clk); #1;
    clr              = 1'b0;
    bus_if.req_valid = 1'b0;
    check_eq("clr_wins_busy", 32'(busy), 32'd0);
    check_eq("clr_wins_valid", 32'(bus_if.res_valid), 32'd0);

    // Asynchronous reset mid-MUL
    issue(OP_MUL, 8'd200, 8'd3, 8'd0, 1'b0);
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    exp_count = 0;
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_req_ready", 32'(bus_if.req_ready), 32'd1);
    check_eq("arst_res_valid", 32'(bus_if.res_valid), 32'd0);
    check_eq("arst_res_data", 32'(bus_if.res_data), 32'd0);
    check_eq("arst_count", 32'(done_count), 32'd0);
`ifdef ALU_SEQ_FLAGS_EN
    check_eq("arst_flags", 32'(bus_if.res_flags), 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;

    // Back-to-back PASS then ADD with wrap
    issue(OP_PASS, 8'd0, 8'd0, 8'hA5, 1'b1);
    issue(OP_ADD, 8'd255, 8'd1, 8'd0, 1'b1);
    @(posedge clk); #1;
    check_eq("b2b_count", 32'(done_count), 32'd2);

    // Counter wrap past 2^CNT_W
    for (int i = 0; i < 17; i++) begin
      issue(OP_PASS, 8'd0, 8'd0, 8'($urandom_range(0, 255)), 1'b1);
    end
    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk); #1;
    check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
    check_eq("wrap_count", 32'(done_count), 32'd3);
    check_eq("wrap_model", 32'(done_count), 32'(exp_count & 15));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
